// File: rtl/vga_timing_gen_if.sv
// Video timing/pixel bus between the VGA timing generator and its consumer.
//   mode                 : pattern select, driven by the consumer side
//   red_F/green_F/blue_F : registered pixel colour, COLOR_W bits per channel
//   hsync/vsync          : registered sync outputs
//   x_pos/y_pos          : position of the pixel currently presented
//   active               : presented pixel is in the visible area
//   frame_start          : one-clock pulse with the tick presenting (0,0)
//   pixel_tick           : one-clock pixel enable
interface vga_timing_gen_if #(
  parameter int COLOR_W = 1,
  parameter int X_W     = 10,
  parameter int Y_W     = 10
);
  logic [1:0]         mode;
  logic [COLOR_W-1:0] red_F;
  logic [COLOR_W-1:0] green_F;
  logic [COLOR_W-1:0] blue_F;
  logic               hsync;
  logic               vsync;
  logic [X_W-1:0]     x_pos;
  logic [Y_W-1:0]     y_pos;
  logic               active;
  logic               frame_start;
  logic               pixel_tick;

  modport master (
    input  mode,
    output red_F, green_F, blue_F, hsync, vsync,
    output x_pos, y_pos, active, frame_start, pixel_tick
  );

  modport slave (
    output mode,
    input  red_F, green_F, blue_F, hsync, vsync,
    input  x_pos, y_pos, active, frame_start, pixel_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator with a built-in test-pattern source.
// A clock divider produces one pixel_tick every CLK_DIV clocks; on each tick
// the h/v raster counters advance and every presented output is registered
// from the pre-increment (h,v), so position, syncs, active and colour stay
// aligned with one tick of latency.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   vga     : master side of vga_timing_gen_if (mode in, timing/pixels out)
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 4,
  parameter int COLOR_W    = 1,
  parameter bit SYNC_POL   = 1'b0,
  parameter int RECT_X0    = 200,
  parameter int RECT_X1    = 635,
  parameter int RECT_Y0    = 200,
  parameter int RECT_Y1    = 475,
  parameter int CHECK_LOG2 = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] RX0      = HW'(RECT_X0);
  localparam logic [HW-1:0] RX1      = HW'(RECT_X1);
  localparam logic [VW-1:0] RY0      = VW'(RECT_Y0);
  localparam logic [VW-1:0] RY1      = VW'(RECT_Y1);
  localparam logic [HW-1:0] BAR_DIV  = HW'(H_ACTIVE / 8);

  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [1:0]    mode_r;
  logic          tick;
  logic          h_last;
  logic          frame_first;
  logic [1:0]    mode_eff;
  logic          vis;
  logic          in_rect;
  logic          chk;
  logic [2:0]    bar_val;
  logic [2:0]    rgb_on;

  // With CLK_DIV=1 div is stuck at 0 and tick is permanently high.
  assign tick = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) div <= '0;
    else          div <= tick ? '0 : div + 1'b1;
  end

  assign h_last      = (h == H_LAST);
  assign frame_first = (h == '0) && (v == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h      <= '0;
      v      <= '0;
      mode_r <= '0;
    end else if (tick) begin
      h <= h_last ? '0 : h + 1'b1;
      if (h_last) v <= (v == V_LAST) ? '0 : v + 1'b1;
      if (frame_first) mode_r <= vga.mode;
    end
  end

  // The (0,0) pixel already belongs to the new frame, so it uses the mode
  // being captured on that same tick rather than the stale register.
  assign mode_eff = frame_first ? vga.mode : mode_r;

  assign vis     = (h < H_VIS) && (v < V_VIS);
  assign in_rect = (h >= RX0) && (h <= RX1) && (v >= RY0) && (v <= RY1);
  assign chk     = h[CHECK_LOG2] ^ v[CHECK_LOG2];
  // {r,g,b} = 7 - bar index; only evaluated while visible so index < 8.
  assign bar_val = 3'd7 - 3'(h / BAR_DIV);

  always_comb begin
    rgb_on = 3'b000;
    if (vis) begin
      case (mode_eff)
        2'd1:    rgb_on = in_rect ? 3'b111 : 3'b000;
        2'd2:    rgb_on = bar_val;
        2'd3:    rgb_on = chk ? 3'b111 : 3'b000;
        default: rgb_on = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vga.x_pos       <= '0;
      vga.y_pos       <= '0;
      vga.active      <= 1'b0;
      vga.hsync       <= ~SYNC_POL;
      vga.vsync       <= ~SYNC_POL;
      vga.red_F       <= '0;
      vga.green_F     <= '0;
      vga.blue_F      <= '0;
      vga.frame_start <= 1'b0;
      vga.pixel_tick  <= 1'b0;
    end else begin
      vga.pixel_tick  <= tick;
      vga.frame_start <= tick & frame_first;
      if (tick) begin
        vga.x_pos   <= h;
        vga.y_pos   <= v;
        vga.active  <= vis;
        vga.hsync   <= ((h >= HS_START) && (h < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vga.vsync   <= ((v >= VS_START) && (v < VS_END)) ? SYNC_POL : ~SYNC_POL;
        vga.red_F   <= {COLOR_W{rgb_on[2]}};
        vga.green_F <= {COLOR_W{rgb_on[1]}};
        vga.blue_F  <= {COLOR_W{rgb_on[0]}};
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances on a reduced raster (24x15) so
// whole frames fit in a short run. dut0: CLK_DIV=3, COLOR_W=4, active-low
// syncs. dut1: CLK_DIV=1, COLOR_W=1, active-high syncs. A reference model
// derives every output from the clock count since reset release; table
// vectors and hand sequences cover pattern boundaries and multi-cycle timing.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 10, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
  localparam int RX0 = 4, RX1 = 15, RY0 = 3, RY1 = 9, CL = 2;
  localparam int CD0 = 3, CW0 = 4;
  localparam bit POL0 = 1'b0;
  localparam int CD1 = 1, CW1 = 1;
  localparam bit POL1 = 1'b1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  vga_timing_gen_if #(.COLOR_W(CW0), .X_W(XW), .Y_W(YW)) bus0 ();
  vga_timing_gen_if #(.COLOR_W(CW1), .X_W(XW), .Y_W(YW)) bus1 ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(CD0), .COLOR_W(CW0), .SYNC_POL(POL0),
    .RECT_X0(RX0), .RECT_X1(RX1), .RECT_Y0(RY0), .RECT_Y1(RY1), .CHECK_LOG2(CL)
  ) dut0 (.clock(clock), .reset_n(reset_n), .vga(bus0));

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(CD1), .COLOR_W(CW1), .SYNC_POL(POL1),
    .RECT_X0(RX0), .RECT_X1(RX1), .RECT_Y0(RY0), .RECT_Y1(RY1), .CHECK_LOG2(CL)
  ) dut1 (.clock(clock), .reset_n(reset_n), .vga(bus1));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] r, g, b;
    logic       hs, vs;
    int         x, y;
    logic       act, fs, tk;
  } out_t;

  typedef struct {
    logic [1:0]  mode;
    int          x, y;
    logic [11:0] rgb;
  } vec_t;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout waiting for %s", name);
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] pattern(input int m, input int x, input int y);
    case (m)
      1: return (x >= RX0 && x <= RX1 && y >= RY0 && y <= RY1) ? 3'd7 : 3'd0;
      2: return 3'(7 - x / (HA / 8));
      3: return (((x >> CL) ^ (y >> CL)) & 1) != 0 ? 3'd7 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [32:0] pack(input out_t e);
    return {e.r, e.g, e.b, e.hs, e.vs, 8'(e.x), 8'(e.y), e.act, e.fs, e.tk};
  endfunction

  int n = 0;      // rising edges since reset release
  int fm0 = 0;    // frame mode the model believes each instance is using
  int fm1 = 0;

  task automatic model_inst(input int cd, input int cw, input bit pol,
                            input logic [1:0] m_in, inout int fm, output out_t e);
    int k, p;
    logic [2:0] pat;
    logic [3:0] msk;
    msk = 4'((1 << cw) - 1);
    e.r = '0; e.g = '0; e.b = '0;
    e.hs = ~pol; e.vs = ~pol;
    e.x = 0; e.y = 0;
    e.act = 1'b0; e.fs = 1'b0; e.tk = 1'b0;
    if (!reset_n) fm = 0;
    if (reset_n && n >= cd) begin
      k = n / cd - 1;             // index of the most recent tick
      p = k % FT;                 // pixel it presents, in raster order
      e.tk = (n % cd == 0);
      if (e.tk && p == 0) fm = m_in;
      e.fs  = e.tk && p == 0;
      e.x   = p % HT;
      e.y   = p / HT;
      e.act = (e.x < HA) && (e.y < VA);
      e.hs  = (e.x >= HA + HFP && e.x < HA + HFP + HS) ? pol : ~pol;
      e.vs  = (e.y >= VA + VFP && e.y < VA + VFP + VS) ? pol : ~pol;
      if (e.act) begin
        pat = pattern(fm, e.x, e.y);
        e.r = pat[2] ? msk : 4'h0;
        e.g = pat[1] ? msk : 4'h0;
        e.b = pat[0] ? msk : 4'h0;
      end
    end
  endtask

  initial begin
    out_t e0, e1;
    logic [32:0] a0, a1;
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n) n = 0;
      else          n = n + 1;
      model_inst(CD0, CW0, POL0, bus0.mode, fm0, e0);
      model_inst(CD1, CW1, POL1, bus1.mode, fm1, e1);
      a0 = {bus0.red_F, bus0.green_F, bus0.blue_F, bus0.hsync, bus0.vsync,
            8'(bus0.x_pos), 8'(bus0.y_pos), bus0.active, bus0.frame_start, bus0.pixel_tick};
      a1 = {4'(bus1.red_F), 4'(bus1.green_F), 4'(bus1.blue_F), bus1.hsync, bus1.vsync,
            8'(bus1.x_pos), 8'(bus1.y_pos), bus1.active, bus1.frame_start, bus1.pixel_tick};
      check($sformatf("model dut0 n=%0d", n), a0, pack(e0));
      check($sformatf("model dut1 n=%0d", n), a1, pack(e1));
    end
  end

  // ---------------- helpers for directed sequences ----------------
  task automatic wait_fs0(input string name);
    for (int i = 0; i < FT * CD0 + 16; i++) begin
      step();
      if (bus0.frame_start) return;
    end
    timeout(name);
  endtask

  task automatic wait_xy0(input int x, input int y, input string name);
    for (int i = 0; i < 2 * FT * CD0 + 16; i++) begin
      step();
      if (bus0.pixel_tick && int'(bus0.x_pos) == x && int'(bus0.y_pos) == y) return;
    end
    timeout(name);
  endtask

  function automatic logic [11:0] rgb0();
    return {bus0.red_F, bus0.green_F, bus0.blue_F};
  endfunction

  vec_t vecs[16];

  initial begin
    int ft0, ft1, cnt, per, act;
    logic prev, found;
    logic [1:0] last_mode;

    vecs[0]  = '{2'd1,  4, 3, 12'hFFF};
    vecs[1]  = '{2'd1, 15, 9, 12'hFFF};
    vecs[2]  = '{2'd1,  3, 3, 12'h000};
    vecs[3]  = '{2'd1,  4, 2, 12'h000};
    vecs[4]  = '{2'd1, 16, 5, 12'h000};
    vecs[5]  = '{2'd2,  0, 0, 12'hFFF};
    vecs[6]  = '{2'd2,  2, 1, 12'hFF0};
    vecs[7]  = '{2'd2,  5, 2, 12'hF0F};
    vecs[8]  = '{2'd2,  9, 3, 12'h0FF};
    vecs[9]  = '{2'd2, 14, 9, 12'h000};
    vecs[10] = '{2'd2, 17, 2, 12'h000};
    vecs[11] = '{2'd3,  4, 0, 12'hFFF};
    vecs[12] = '{2'd3,  4, 4, 12'h000};
    vecs[13] = '{2'd3,  0, 4, 12'hFFF};
    vecs[14] = '{2'd3,  3, 3, 12'h000};
    vecs[15] = '{2'd0,  5, 5, 12'h000};

    bus0.mode = 2'd0;
    bus1.mode = 2'd0;

    // Reset state
    repeat (3) step();
    check("reset x_pos", bus0.x_pos, 0);
    check("reset y_pos", bus0.y_pos, 0);
    check("reset hsync0", bus0.hsync, 1);
    check("reset vsync1", bus1.vsync, 0);
    check("reset rgb0", rgb0(), 0);
    check("reset tick/act/fs", {bus0.pixel_tick, bus0.active, bus0.frame_start}, 0);

    // First tick latency after release
    reset_n = 1'b1;
    ft0 = 0; ft1 = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (ft0 == 0 && bus0.pixel_tick) ft0 = i;
      if (ft1 == 0 && bus1.pixel_tick) ft1 = i;
    end
    check("first tick dut0", ft0, CD0);
    check("first tick dut1", ft1, CD1);
    check("dut1 tick steady", bus1.pixel_tick, 1);

    // Random modes, mid-frame changes included, checked by the model
    for (int i = 0; i < 6000; i++) begin
      step();
      if ($urandom_range(0, 149) == 0) bus0.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) bus1.mode = 2'($urandom_range(0, 3));
    end

    // Pattern boundary table on dut0
    last_mode = 2'bxx;
    foreach (vecs[i]) begin
      if (vecs[i].mode !== last_mode) begin
        bus0.mode = vecs[i].mode;
        bus1.mode = vecs[i].mode;
        last_mode = vecs[i].mode;
        wait_fs0("frame_start (table)");
      end
      wait_xy0(vecs[i].x, vecs[i].y, "table pixel");
      check($sformatf("table m%0d (%0d,%0d)", vecs[i].mode, vecs[i].x, vecs[i].y),
            rgb0(), vecs[i].rgb);
    end

    // hsync pulse width and period in clocks
    prev = bus0.hsync; found = 1'b0;
    for (int i = 0; i < 4 * HT * CD0 && !found; i++) begin
      step();
      if (prev == ~POL0 && bus0.hsync == POL0) found = 1'b1;
      prev = bus0.hsync;
    end
    if (!found) timeout("hsync fall");
    cnt = 0;
    do begin step(); cnt++; end while (bus0.hsync == POL0 && cnt < 4 * HT * CD0);
    check("hsync low clocks", cnt, HS * CD0);
    per = cnt;
    do begin step(); per++; end while (bus0.hsync != POL0 && per < 4 * HT * CD0);
    check("hsync period clocks", per, HT * CD0);

    // vsync: first low line and low duration in ticks
    prev = bus0.vsync; found = 1'b0;
    for (int i = 0; i < 2 * FT * CD0 && !found; i++) begin
      step();
      if (prev == ~POL0 && bus0.vsync == POL0) found = 1'b1;
      prev = bus0.vsync;
    end
    if (!found) timeout("vsync fall");
    check("vsync start line", {8'(bus0.y_pos), 8'(bus0.x_pos)}, {8'(VA + VFP), 8'd0});
    cnt = 1;
    for (int i = 0; i < 2 * FT * CD0 && bus0.vsync == POL0; i++) begin
      step();
      if (bus0.vsync == POL0 && bus0.pixel_tick) cnt++;
    end
    check("vsync low ticks", cnt, VS * HT);

    // frame_start spacing and visible ticks per frame
    wait_fs0("frame_start (spacing)");
    cnt = 0; act = 1;
    for (int i = 0; i < 2 * FT * CD0; i++) begin
      step();
      cnt++;
      if (bus0.frame_start) break;
      if (bus0.pixel_tick && bus0.active) act++;
    end
    check("frame_start spacing clocks", cnt, FT * CD0);
    check("active ticks per frame", act, HA * VA);

    // Mode change mid-frame only takes effect at the next frame
    bus0.mode = 2'd1;
    wait_fs0("frame_start (switch)");
    wait_xy0(0, 5, "switch line");
    bus0.mode = 2'd3;
    wait_xy0(4, 6, "rect after switch");
    check("still rect (4,6)", rgb0(), 12'hFFF);
    wait_fs0("frame_start (new mode)");
    wait_xy0(4, 0, "checker (4,0)");
    check("checker (4,0)", rgb0(), 12'hFFF);
    wait_xy0(4, 4, "checker (4,4)");
    check("checker (4,4)", rgb0(), 12'h000);

    // Asynchronous reset mid-line on the CLK_DIV=1 instance
    found = 1'b0;
    for (int i = 0; i < 2 * HT && !found; i++) begin
      step();
      if (int'(bus1.x_pos) == 10) found = 1'b1;
    end
    if (!found) timeout("dut1 mid-line");
    reset_n = 1'b0;
    #1;
    check("async rst x_pos1", bus1.x_pos, 0);
    check("async rst hsync1/vsync1", {bus1.hsync, bus1.vsync}, {~POL1, ~POL1});
    check("async rst tick1", bus1.pixel_tick, 0);
    check("async rst x_pos0", bus0.x_pos, 0);
    repeat (2) step();
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      cnt++;
      if (bus1.frame_start) break;
    end
    check("dut1 first frame_start clocks", cnt, 1);
    cnt = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      step();
      cnt++;
      if (bus1.frame_start) break;
    end
    check("dut1 frame period clocks", cnt, FT * CD1);

    repeat (20) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
